// File: rtl/booth_mul_seq_if.sv
// Handshake bundle for booth_mul_seq.
//   master : operand source / result consumer (drives A, B, alu_signed,
//            in_valid, out_ready)
//   slave  : the multiplier (drives in_ready, out_valid, PROD_RESULT,
//            neg_flag, zero_flag, busy)
interface booth_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 alu_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   PROD_RESULT;
  logic                 neg_flag;
  logic                 zero_flag;
  logic                 busy;

  modport master (
    output in_valid, A, B, alu_signed, out_ready,
    input  in_ready, out_valid, PROD_RESULT, neg_flag, zero_flag, busy
  );

  modport slave (
    input  in_valid, A, B, alu_signed, out_ready,
    output in_ready, out_valid, PROD_RESULT, neg_flag, zero_flag, busy
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one Booth digit retired per clock.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : booth_mul_seq_if.slave
//              in  : in_valid, A, B, alu_signed, out_ready
//              out : in_ready, out_valid, PROD_RESULT, neg_flag,
//                    zero_flag, busy
// WIDTH must be even and >= 4. Result is valid WIDTH/2+1 edges after the
// accepting edge and is held until out_ready.
module booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  booth_mul_seq_if.slave  bus
);
  localparam int N     = WIDTH/2 + 1;     // Booth digits
  localparam int AW    = WIDTH + 2;       // extended operand width
  localparam int ACC_W = 2*WIDTH + 4;
  localparam int CW    = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        step;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     mcand;   // A_ext * 4^step, sign-extended to ACC_W
  logic [AW:0]          mplr;    // B_ext with the recoding 0 appended, shifted right 2/step
  logic                 sgn;
  logic                 in_ready_q, out_valid_q, busy_q, neg_q, zero_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic [AW-1:0]        a_ext, b_ext;
  logic [ACC_W-1:0]     pp, acc_nxt;

  // Extension by 2 bits keeps the top Booth digit non-negative for
  // unsigned operands and representable for signed min*min.
  assign a_ext = {{2{bus.alu_signed & bus.A[WIDTH-1]}}, bus.A};
  assign b_ext = {{2{bus.alu_signed & bus.B[WIDTH-1]}}, bus.B};

  // Booth recode of the low 3 multiplier bits; the accumulator wraps mod
  // 2^ACC_W so negative partial products are plain two's complement.
  always_comb begin
    pp = '0;
    case (mplr[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    acc_nxt = acc + pp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      step        <= '0;
      acc         <= '0;
      mcand       <= '0;
      mplr        <= '0;
      sgn         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      prod_q      <= '0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mcand      <= {{(ACC_W-AW){a_ext[AW-1]}}, a_ext};
          mplr       <= {b_ext, 1'b0};
          sgn        <= bus.alu_signed;
          acc        <= '0;
          step       <= '0;
          state      <= CALC;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        CALC: begin
          acc   <= acc_nxt;
          mcand <= mcand << 2;
          mplr  <= {{2{mplr[AW]}}, mplr[AW:2]};
          step  <= step + CW'(1);
          if (step == CW'(N-1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            prod_q      <= acc_nxt[2*WIDTH-1:0];
            neg_q       <= sgn & acc_nxt[2*WIDTH-1];
            zero_q      <= (acc_nxt[2*WIDTH-1:0] == '0);
          end
        end
        DONE: if (bus.out_ready) begin
          // in_ready only rises on the following cycle: no accept on drain.
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.PROD_RESULT = prod_q;
  assign bus.neg_flag    = neg_q;
  assign bus.zero_flag   = zero_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed corners on a 16-bit instance plus
// randomized ops on WIDTH 4/8/16/32 instances against a plain-multiply model.
module tb_booth_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;    // directed instance
  logic rst_r = 1'b0;  // random sweep instances
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- directed 16-bit instance ----------------
  booth_mul_seq_if #(.WIDTH(16)) d16 ();
  booth_mul_seq #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(d16));

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s);
    int n = 0;
    @(negedge clk);
    d16.A = a; d16.B = b; d16.alu_signed = s; d16.in_valid = 1'b1;
    while (!d16.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    // scramble everything after the accepting edge; must not matter
    #1 d16.in_valid = 1'b0; d16.A = ~a; d16.B = ~b; d16.alu_signed = ~s;
  endtask

  task automatic wait_valid16(output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!d16.out_valid && lat < 100);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] ep, input logic en, input logic ez);
    int lat;
    d16.out_ready = 1'b1;
    issue16(a, b, s);
    wait_valid16(lat);
    chk({tag, "_lat"},  64'(lat), 64'd9);
    chk({tag, "_prod"}, 64'(d16.PROD_RESULT), 64'(ep));
    chk({tag, "_neg"},  64'(d16.neg_flag), 64'(en));
    chk({tag, "_zero"}, 64'(d16.zero_flag), 64'(ez));
    @(negedge clk);
    chk({tag, "_drain"}, 64'({d16.out_valid, d16.in_ready}), 64'b01);
  endtask

  // ---------------- random sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : gw
    localparam int W = 4 << g;
    booth_mul_seq_if #(.WIDTH(W)) bus ();
    booth_mul_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst_r), .bus(bus));
    bit done = 1'b0;

    initial begin
      logic [W-1:0] a, b;
      logic         s;
      logic [63:0]  ae, be, mask, exp;
      int           lat, hold, stall_bad;
      stall_bad = 0;
      bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.alu_signed = 1'b0; bus.out_ready = 1'b0;
      mask = (64'd1 << (2*W)) - 64'd1;
      @(negedge clk);
      while (rst_r) @(negedge clk);
      for (int i = 0; i < 200; i++) begin
        a = W'($urandom); b = W'($urandom); s = 1'($urandom);
        if (i % 8 == 0) begin a = '0; a[W-1] = 1'b1; b = a; end  // min*min / 2^(W-1) squared
        if (i % 8 == 1) begin a = '1; b = '1; end
        ae  = s ? 64'($signed(a)) : 64'(a);
        be  = s ? 64'($signed(b)) : 64'(b);
        exp = (ae * be) & mask;
        bus.A = a; bus.B = b; bus.alu_signed = s; bus.in_valid = 1'b1;
        bus.out_ready = 1'($urandom);
        hold = 0;
        while (!bus.in_ready && hold < 100) begin @(negedge clk); hold++; end
        @(posedge clk);
        #1 bus.in_valid = 1'b0; bus.A = ~a; bus.B = W'($urandom); bus.alu_signed = ~s;
        lat = 0;
        do begin
          @(posedge clk); lat++;
          @(negedge clk);
          if (!bus.out_valid) bus.out_ready = 1'($urandom);
        end while (!bus.out_valid && lat < 100);
        chk($sformatf("w%0d_lat", W),  64'(lat), 64'(W/2 + 1));
        chk($sformatf("w%0d_prod a=%0h b=%0h s=%0d", W, a, b, s), 64'(bus.PROD_RESULT), exp);
        chk($sformatf("w%0d_neg", W),  64'(bus.neg_flag), 64'(s & exp[2*W-1]));
        chk($sformatf("w%0d_zero", W), 64'(bus.zero_flag), 64'(exp == 64'd0));
        hold = 0;
        while (!bus.out_ready && hold < 8) begin
          @(posedge clk); @(negedge clk);
          if (!bus.out_valid || 64'(bus.PROD_RESULT) !== exp || bus.in_ready) stall_bad++;
          bus.out_ready = (hold >= 4) ? 1'b1 : 1'($urandom);
          hold++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        if (bus.out_valid || !bus.in_ready) stall_bad++;
      end
      chk($sformatf("w%0d_stall_stable", W), 64'(stall_bad), 64'd0);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence + summary ----------------
  initial begin
    int lat, bad, n;
    logic [31:0] p;
    d16.in_valid = 1'b0; d16.A = '0; d16.B = '0; d16.alu_signed = 1'b0; d16.out_ready = 1'b1;
    #1 rst = 1'b1; rst_r = 1'b1;
    #2;
    chk("rst_ctl",  64'({d16.in_ready, d16.out_valid, d16.busy, d16.neg_flag, d16.zero_flag}), 64'b10000);
    chk("rst_prod", 64'(d16.PROD_RESULT), 64'd0);
    @(negedge clk); rst = 1'b0; rst_r = 1'b0;

    run16("u_ffff_sq",  16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0, 1'b0);
    run16("u_zero",     16'h0000, 16'hABCD, 1'b0, 32'h00000000, 1'b0, 1'b1);
    run16("s_m12x3",    16'hFFF4, 16'h0003, 1'b1, 32'hFFFFFFDC, 1'b1, 1'b0);
    run16("s_m15xm2",   16'hFFF1, 16'hFFFE, 1'b1, 32'd30,       1'b0, 1'b0);
    run16("s_maxx2",    16'h7FFF, 16'h0002, 1'b1, 32'd65534,    1'b0, 1'b0);
    run16("s_minx1",    16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 1'b1, 1'b0);
    run16("s_minxmin",  16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b0, 1'b0);
    run16("mix_u",      16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, 1'b0, 1'b0);
    run16("mix_s",      16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);

    // reset in the middle of a calculation
    d16.out_ready = 1'b1;
    issue16(16'h1234, 16'h0056, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ctl",  64'({d16.in_ready, d16.out_valid, d16.busy}), 64'b100);
    chk("midrst_prod", 64'(d16.PROD_RESULT), 64'd0);
    @(negedge clk); rst = 1'b0;
    run16("post_rst", 16'd5, 16'd7, 1'b0, 32'd35, 1'b0, 1'b0);

    // backpressure: stall 20 cycles with a competing in_valid
    d16.out_ready = 1'b0;
    issue16(16'hFFF4, 16'h0003, 1'b1);
    wait_valid16(lat);
    chk("bp_lat",  64'(lat), 64'd9);
    chk("bp_prod", 64'(d16.PROD_RESULT), 64'hFFFFFFDC);
    p = d16.PROD_RESULT;
    bad = 0;
    d16.in_valid = 1'b1; d16.A = 16'd7; d16.B = 16'd9; d16.alu_signed = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (d16.PROD_RESULT !== p || !d16.out_valid || d16.in_ready || !d16.neg_flag || d16.zero_flag) bad++;
    end
    chk("bp_stable", 64'(bad), 64'd0);
    d16.in_valid = 1'b0; d16.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'({d16.out_valid, d16.in_ready, d16.busy}), 64'b010);
    @(negedge clk);
    chk("bp_idle", 64'({d16.out_valid, d16.busy}), 64'b00);

    n = 0;
    while (!(gw[0].done && gw[1].done && gw[2].done && gw[3].done) && n < 80000) begin
      @(negedge clk); n++;
    end
    if (n >= 80000) chk("random_timeout", 64'd1, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Parametrised, iterative radix-4 Booth multiplier with signed/unsigned mode and valid/ready handshakes on both sides. It is the sequential, width-generic successor to the 16x16 single-cycle combinational Booth multiplier. It trades latency for area by retiring one radix-4 digit per clock. It sits behind the ALU issue stage and returns a full-width product plus negative and zero flags.

## Interface
- WIDTH, 16, operand width in bits; must be even and >= 4
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands; high only in IDLE
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- alu_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with A/B
- out_valid  output  1  PROD_RESULT and flags are valid
- out_ready  input  1  consumer accepts result
- PROD_RESULT  output  2*WIDTH  product
- neg_flag  output  1  product negative (signed mode only)
- zero_flag  output  1  product equals zero
- busy  output  1  state is CALC or DONE

## Operation
- Define N = WIDTH/2 + 1, the number of Booth digits. For WIDTH=16, N=9.
- States: IDLE, CALC, DONE.
- IDLE: a transfer occurs when in_valid and in_ready are both high at a clock edge.
  - A, B and alu_signed are captured.
  - The step counter clears and the accumulator clears.
  - State goes to CALC.
  - Input changes after the accepting edge are ignored.
- Operand extension to WIDTH+2 bits: sign-extend when alu_signed=1, zero-extend when 0. The multiplier gets an appended 0 LSB for recoding.
- CALC performs one step per edge:
  - Recode 3 multiplier bits into a digit in {-2,-1,0,+1,+2}.
  - Add digit*A_ext, shifted by 2*step, into an accumulator of 2*WIDTH+4 bits, or use an equivalent shift-right scheme.
  - Negative digits are formed as the two's complement of ±A_ext or ±2*A_ext.
- After step N-1 completes, state goes to DONE and the outputs register:
  - PROD_RESULT = low 2*WIDTH bits of the accumulator.
  - neg_flag = alu_signed & PROD_RESULT[2*WIDTH-1].
  - zero_flag = (PROD_RESULT == 0).
- Result must equal $signed(A)*$signed(B) in signed mode and A*B in unsigned mode, exactly, for all inputs.
- Signed mode includes min*min. For WIDTH=16, -32768*-32768 = 0x40000000.
- DONE: out_valid=1. Outputs hold stable until an edge with out_ready=1, then state goes to IDLE and out_valid drops.
- PROD_RESULT and the flags keep their last value in IDLE and CALC. Consumers qualify them with out_valid only.
- No accept in the same cycle as drain: in_ready=0 in DONE even when out_ready=1.

## Timing
- Reset values (async, immediate on rst=1):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - PROD_RESULT=0, neg_flag=0, zero_flag=0; counter and accumulator cleared.
- Reset asserted in CALC or DONE aborts the operation. No out_valid is produced for it.
- Latency: accept at edge E0, out_valid high after edge E_N and visible in the cycle following E_N. For WIDTH=16, out_valid is high after the 9th edge following acceptance.
- Minimum initiation interval is N+2 cycles: accept, N steps, one drain cycle back to IDLE, assuming out_ready is held high.
- out_ready low stalls indefinitely in DONE with all outputs stable.
- in_valid asserted while busy is ignored. The source must hold A/B/in_valid until in_ready.

## Test plan
- Reset mid-CALC: accept A=0x1234, B=0x0056; assert rst after 4 edges. Required: out_valid=0, in_ready=1 and PROD_RESULT=0 immediately. Next op 5*7 unsigned gives 35 with correct latency.
- Unsigned corners, WIDTH=16:
  - 0xFFFF*0xFFFF gives 0xFFFE0001, neg_flag=0.
  - 0*0xABCD gives 0 with zero_flag=1.
  - Each out_valid arrives exactly 9 edges after accept.
- Signed corners, WIDTH=16:
  - -12*3 gives 0xFFFFFFDC, neg_flag=1.
  - -15*-2 gives 30.
  - 32767*2 gives 65534.
  - -32768*1 gives 0xFFFF8000.
  - -32768*-32768 gives 0x40000000, neg_flag=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Required: result/flags stable, in_ready=0, and a new in_valid is not accepted. Release gives one transfer, then IDLE.
- Mode mixing: the same operands 0xFFFF*0x0002 give 0x0001FFFE unsigned and 0xFFFFFFFE signed with neg_flag=1. alu_signed toggled after accept does not alter the result.
- Parameter sweep: WIDTH in {4, 8, 16, 32}. Run 200 random ops each, both modes, random out_ready. Compare against the native reference product; latency equals WIDTH/2+1.
